data_mem_responder: RTL and testbench

//  Responder end of the CPU data-memory port: accepts load/store requests (address = ALU result,

---
 rtl/mem_pkg.sv | 21 ++
 rtl/lsu_lane_align.sv | 38 +++
 rtl/data_mem_responder.sv | 184 ++++++++++++++++++
 tb/tb_data_mem_responder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the CPU data-memory responder.
// Holds funct3 access widths, FSM states and the default MMIO window base.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] MMIO_BASE_DEF = 32'hF000_0000;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        RDWAIT,
        MMIO_WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for stores and lane select plus sign/zero extension for loads.
// Purely combinational; shared by the RAM and MMIO paths.
module lsu_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  mask,
    output logic [31:0] wdata_steered,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted;

    assign shifted = rdata >> {off, 3'b000};

    always_comb begin
        mask          = 4'hF;
        wdata_steered = wdata;
        rdata_ext     = shifted;
        unique case (funct3)
            F3_B, F3_BU: begin
                mask          = 4'b0001 << off;
                wdata_steered = {4{wdata[7:0]}};
                rdata_ext     = {{24{shifted[7] & ~funct3[2]}}, shifted[7:0]};
            end
            F3_H, F3_HU: begin
                mask          = 4'b0011 << off;
                wdata_steered = {2{wdata[15:0]}};
                rdata_ext     = {{16{shifted[15] & ~funct3[2]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the CPU data-memory port: serves loads/stores from a
// 1-cycle block RAM or an MMIO window, one response per request.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int          RAM_ADDR_W   = 12,
    parameter logic [31:0] MMIO_BASE    = MMIO_BASE_DEF,
    parameter int          MMIO_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  ram_en,
    output logic [3:0]            ram_we,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata,
    output logic                  mmio_valid,
    output logic                  mmio_we,
    output logic [3:0]            mmio_be,
    output logic [31:0]           mmio_addr,
    output logic [31:0]           mmio_wdata,
    input  logic [31:0]           mmio_rdata,
    input  logic                  mmio_ready
);

    localparam int CNT_W = $clog2(MMIO_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MMIO_TIMEOUT - 1);

    state_t state_q, state_d;

    logic             we_q;
    logic [2:0]       f3_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      rdata_q;
    logic             err_q;

    logic f3_ok, align_ok, hit_mmio, hit_ram, dec_err;
    logic timeout;

    logic [3:0]  lane_mask;
    logic [31:0] lane_wdata, lane_rdata, rd_raw;

    always_comb begin
        f3_ok    = 1'b0;
        align_ok = 1'b1;
        unique case (req_funct3)
            F3_B:  f3_ok = 1'b1;
            F3_H: begin
                f3_ok    = 1'b1;
                align_ok = !req_addr[0];
            end
            F3_W: begin
                f3_ok    = 1'b1;
                align_ok = (req_addr[1:0] == 2'b00);
            end
            F3_BU: f3_ok = !req_we;
            F3_HU: begin
                f3_ok    = !req_we;
                align_ok = !req_addr[0];
            end
            default: f3_ok = 1'b0;
        endcase
    end

    assign hit_mmio = (req_addr >= MMIO_BASE);
    assign hit_ram  = ((req_addr >> (RAM_ADDR_W + 2)) == 32'd0);
    assign dec_err  = !f3_ok || !align_ok || !(hit_mmio || hit_ram);
    assign timeout  = (cnt_q == CNT_LAST);
    assign rd_raw   = (state_q == RDWAIT) ? ram_rdata : mmio_rdata;

    lsu_lane_align u_lane (
        .funct3        (f3_q),
        .off           (addr_q[1:0]),
        .wdata         (wdata_q),
        .rdata         (rd_raw),
        .mask          (lane_mask),
        .wdata_steered (lane_wdata),
        .rdata_ext     (lane_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        ram_en     = 1'b0;
        ram_we     = 4'h0;
        ram_addr   = '0;
        ram_wdata  = 32'h0;
        mmio_valid = 1'b0;
        mmio_we    = 1'b0;
        mmio_be    = 4'h0;
        mmio_addr  = 32'h0;
        mmio_wdata = 32'h0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (dec_err)       state_d = RESP;
                    else if (hit_mmio) state_d = MMIO_WAIT;
                    else               state_d = ACCESS;
                end
            end
            ACCESS: begin
                ram_en    = 1'b1;
                ram_we    = we_q ? lane_mask : 4'h0;
                ram_addr  = addr_q[RAM_ADDR_W+1:2];
                ram_wdata = lane_wdata;
                state_d   = we_q ? RESP : RDWAIT;
            end
            RDWAIT: state_d = RESP;
            MMIO_WAIT: begin
                mmio_valid = 1'b1;
                mmio_we    = we_q;
                mmio_be    = lane_mask;
                mmio_addr  = {addr_q[31:2], 2'b00};
                mmio_wdata = lane_wdata;
                if (mmio_ready || timeout) state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Response fields only change on the cycle that enters RESP
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            cnt_q   <= '0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            if (state_q == MMIO_WAIT && !mmio_ready) cnt_q <= cnt_q + 1'b1;
            else                                     cnt_q <= '0;
            if (state_q == IDLE && req_valid) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                if (dec_err) begin
                    rdata_q <= 32'h0;
                    err_q   <= 1'b1;
                end
            end
            if (state_q == ACCESS && we_q) begin
                rdata_q <= 32'h0;
                err_q   <= 1'b0;
            end
            if (state_q == RDWAIT) begin
                rdata_q <= lane_rdata;
                err_q   <= 1'b0;
            end
            if (state_q == MMIO_WAIT && (mmio_ready || timeout)) begin
                rdata_q <= (mmio_ready && !we_q) ? lane_rdata : 32'h0;
                err_q   <= !mmio_ready;
            end
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with a behavioural BRAM and MMIO target.
// Expected values are hand-computed per vector.
module tb_data_mem_responder;

    logic        clk, rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic        mmio_valid, mmio_we, mmio_ready;
    logic [3:0]  mmio_be;
    logic [31:0] mmio_addr, mmio_wdata, mmio_rdata;

    int checks = 0;
    int failures = 0;

    int          lat, en_cnt, mv_cnt;
    logic [31:0] rd;
    logic        er;
    logic [3:0]  we_seen, mbe_seen;
    logic [31:0] wd_seen, ma_seen, mwd_seen;

    logic [31:0] mem [0:4095];
    int          mdelay = -1;
    int          mcnt = 0;
    logic [31:0] mval = 32'h0;

    data_mem_responder dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .mmio_valid (mmio_valid),
        .mmio_we    (mmio_we),
        .mmio_be    (mmio_be),
        .mmio_addr  (mmio_addr),
        .mmio_wdata (mmio_wdata),
        .mmio_rdata (mmio_rdata),
        .mmio_ready (mmio_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural 1-cycle BRAM
    always @(posedge clk) begin
        if (ram_en) begin
            for (int i = 0; i < 4; i++)
                if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
            ram_rdata <= mem[ram_addr];
        end
    end

    // MMIO target: ready mdelay cycles after valid rises (never if negative)
    always @(negedge clk) begin
        if (mmio_valid) begin
            mmio_ready = (mcnt == mdelay);
            mmio_rdata = mval;
            mcnt++;
        end else begin
            mmio_ready = 1'b0;
            mcnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic xact(input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = ~we;
        req_funct3 = 3'b111;
        req_addr   = 32'hFFFF_FFFF;
        req_wdata  = 32'hA5A5_A5A5;
        lat = 0; en_cnt = 0; mv_cnt = 0;
        we_seen = 4'h0; wd_seen = 32'h0;
        ma_seen = 32'h0; mbe_seen = 4'h0; mwd_seen = 32'h0;
        rd = 32'hXXXX_XXXX; er = 1'bx;
        while (lat < 400) begin
            @(negedge clk);
            lat++;
            if (ram_en) begin
                en_cnt++;
                we_seen = ram_we;
                wd_seen = ram_wdata;
            end
            if (mmio_valid) begin
                mv_cnt++;
                ma_seen  = mmio_addr;
                mbe_seen = mmio_be;
                mwd_seen = mmio_wdata;
            end
            if (rsp_valid) begin
                rd = rsp_rdata;
                er = rsp_err;
                break;
            end
        end
    endtask

    int pulses;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        ram_rdata  = 32'h0;
        mmio_ready = 1'b0;
        mmio_rdata = 32'h0;
        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_rsp", {31'h0, rsp_valid}, 32'h0);
        chk("rst_ram_en", {31'h0, ram_en}, 32'h0);
        chk("rst_mmio_v", {31'h0, mmio_valid}, 32'h0);
        chk("rst_ram_we", {28'h0, ram_we}, 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        rst = 1'b1;

        xact(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
        chk("sw_lat", lat, 2);
        chk("sw_we", {28'h0, we_seen}, 32'hF);
        chk("sw_err", {31'h0, er}, 32'h0);
        chk("sw_en_cnt", en_cnt, 1);
        xact(1'b0, 3'b010, 32'h10, 32'h0);
        chk("lw_lat", lat, 3);
        chk("lw_data", rd, 32'hDEAD_BEEF);
        chk("lw_err", {31'h0, er}, 32'h0);

        xact(1'b1, 3'b000, 32'h13, 32'h0000_0080);
        chk("sb_we", {28'h0, we_seen}, 32'h8);
        chk("sb_wd", wd_seen, 32'h8080_8080);
        xact(1'b0, 3'b000, 32'h13, 32'h0);
        chk("lb_data", rd, 32'hFFFF_FF80);
        xact(1'b0, 3'b100, 32'h13, 32'h0);
        chk("lbu_data", rd, 32'h0000_0080);
        xact(1'b0, 3'b001, 32'h12, 32'h0);
        chk("lh_data", rd, 32'hFFFF_80AD);
        xact(1'b0, 3'b101, 32'h10, 32'h0);
        chk("lhu_data", rd, 32'h0000_BEEF);
        xact(1'b1, 3'b001, 32'h16, 32'h0000_1234);
        chk("sh_we", {28'h0, we_seen}, 32'hC);
        chk("sh_wd", wd_seen, 32'h1234_1234);
        xact(1'b0, 3'b010, 32'h14, 32'h0);
        chk("lw_after_sh", rd, 32'h1234_0000);

        xact(1'b0, 3'b001, 32'h11, 32'h0);
        chk("lh_mis_lat", lat, 1);
        chk("lh_mis_err", {31'h0, er}, 32'h1);
        chk("lh_mis_en", en_cnt, 0);
        xact(1'b1, 3'b010, 32'h12, 32'h1);
        chk("sw_mis_err", {31'h0, er}, 32'h1);
        chk("sw_mis_en", en_cnt, 0);
        xact(1'b0, 3'b011, 32'h0, 32'h0);
        chk("f3_011_lat", lat, 1);
        chk("f3_011_err", {31'h0, er}, 32'h1);
        chk("f3_011_rd", rd, 32'h0);
        xact(1'b1, 3'b100, 32'h0, 32'h0);
        chk("sbu_err", {31'h0, er}, 32'h1);
        chk("sbu_en", en_cnt + mv_cnt, 0);

        xact(1'b1, 3'b010, 32'h3FFC, 32'h1122_3344);
        chk("last_sw_err", {31'h0, er}, 32'h0);
        xact(1'b0, 3'b010, 32'h3FFC, 32'h0);
        chk("last_lw", rd, 32'h1122_3344);
        xact(1'b0, 3'b010, 32'h4000, 32'h0);
        chk("oob_err", {31'h0, er}, 32'h1);
        chk("oob_lat", lat, 1);
        chk("oob_en", en_cnt + mv_cnt, 0);

        mdelay = 3; mval = 32'h0000_1234;
        xact(1'b0, 3'b010, 32'hF000_0004, 32'h0);
        chk("mmio_lat", lat, 5);
        chk("mmio_vcnt", mv_cnt, 4);
        chk("mmio_addr", ma_seen, 32'hF000_0004);
        chk("mmio_rd", rd, 32'h0000_1234);
        chk("mmio_err", {31'h0, er}, 32'h0);
        mdelay = 0;
        xact(1'b1, 3'b000, 32'hF000_0001, 32'h0000_005A);
        chk("mmio_sb_lat", lat, 2);
        chk("mmio_sb_be", {28'h0, mbe_seen}, 32'h2);
        chk("mmio_sb_wd", mwd_seen, 32'h5A5A_5A5A);
        chk("mmio_sb_addr", ma_seen, 32'hF000_0000);

        mdelay = -1;
        xact(1'b0, 3'b010, 32'hF000_0008, 32'h0);
        chk("to_lat", lat, 256);
        chk("to_vcnt", mv_cnt, 255);
        chk("to_err", {31'h0, er}, 32'h1);
        chk("to_rd", rd, 32'h0);
        mdelay = 254; mval = 32'hCAFE_F00D;
        xact(1'b0, 3'b010, 32'hF000_0008, 32'h0);
        chk("to_edge_lat", lat, 256);
        chk("to_edge_err", {31'h0, er}, 32'h0);
        chk("to_edge_rd", rd, 32'hCAFE_F00D);

        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h10; req_wdata = 32'h0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        pulses = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_en", {31'h0, ram_en}, 32'h0);
        chk("mid_rst_mv", {31'h0, mmio_valid}, 32'h0);
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        rst = 1'b1;
        #1;
        chk("post_rst_ready", {31'h0, req_ready}, 32'h1);
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        chk("mid_rst_no_rsp", pulses, 0);
        xact(1'b0, 3'b010, 32'h0, 32'h0);
        chk("post_rst_lat", lat, 3);
        chk("post_rst_rd", rd, 32'h0);
        chk("post_rst_err", {31'h0, er}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
